// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and saturation helper for the NN datapath.
// Used by neuron_accumulator and nn_sat_shift.
package nn_pkg;

  localparam int NN_N     = 16;
  localparam int NN_W     = 16;
  localparam int NN_FRAC  = 8;
  localparam int SAT_IN_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } nn_state_t;

  function automatic int acc_w(input int w, input int n);
    return 2 * w + $clog2(n) + 1;
  endfunction

  function automatic logic signed [SAT_IN_W-1:0] sat_to_w(
    input logic signed [SAT_IN_W-1:0] v,
    input int                         w
  );
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/nn_sat_shift.sv
// Rescale by FRAC (floor), saturate to W bits.
// Define NEURON_RELU_EN to clamp negative results to zero.
module nn_sat_shift
  import nn_pkg::*;
#(
  parameter int W    = NN_W,
  parameter int FRAC = NN_FRAC,
  parameter int IN_W = acc_w(NN_W, NN_N)
) (
  input  logic signed [IN_W-1:0] sum,
  output logic signed [W-1:0]    y
);

  logic signed [SAT_IN_W-1:0] wide;
  logic signed [SAT_IN_W-1:0] sat;

  assign wide = SAT_IN_W'(sum) >>> FRAC;
  assign sat  = sat_to_w(wide, W);

`ifdef NEURON_RELU_EN
  assign y = sat[SAT_IN_W-1] ? '0 : W'(sat);
`else
  assign y = W'(sat);
`endif

endmodule

// File: rtl/neuron_accumulator.sv
// MAC over N streamed elements plus bias, rescaled and saturated to W bits.
// Optional ReLU output stage via NEURON_RELU_EN (see nn_sat_shift).
module neuron_accumulator
  import nn_pkg::*;
#(
  parameter int N    = NN_N,
  parameter int W    = NN_W,
  parameter int FRAC = NN_FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_rst,
  input  logic                ld,
  input  logic [15:0]         index,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] w_in,
  input  logic signed [W-1:0] bias,
  output logic signed [W-1:0] y,
  output logic                y_valid,
  output logic                seq_err
);

  localparam int ACC_W = acc_w(W, N);

  nn_state_t state, state_nxt;

  logic [15:0]              exp_idx;
  logic signed [2*W-1:0]    prod_q;
  logic                     v1;
  logic                     last1;
  logic                     last2;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [W-1:0]      bias_q;
  logic signed [W-1:0]      y_nxt;
  logic                     open;
  logic                     accept;
  logic                     is_last;

  assign open    = (state == IDLE) || (state == RUN);
  assign accept  = ld && !reg_rst && open;
  assign is_last = (index == 16'(N - 1));

  assign sum = acc + (ACC_W'(bias_q) <<< FRAC);

  nn_sat_shift #(
    .W    (W),
    .FRAC (FRAC),
    .IN_W (ACC_W)
  ) u_sat (
    .sum (sum),
    .y   (y_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = is_last ? FLUSH : RUN;
      RUN:   if (accept && is_last) state_nxt = FLUSH;
      FLUSH: if (last2) state_nxt = DONE;
      DONE:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (reg_rst) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_idx <= '0;
      prod_q  <= '0;
      v1      <= 1'b0;
      last1   <= 1'b0;
      last2   <= 1'b0;
      acc     <= '0;
      bias_q  <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      seq_err <= 1'b0;
    end else if (reg_rst) begin
      // y is kept; anything still in flight is dropped
      exp_idx <= '0;
      v1      <= 1'b0;
      last1   <= 1'b0;
      last2   <= 1'b0;
      acc     <= '0;
      y_valid <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        prod_q  <= (2*W)'(x_in) * (2*W)'(w_in);
        last1   <= is_last;
        exp_idx <= (exp_idx == 16'(N - 1)) ? '0 : exp_idx + 16'd1;
        if (index != exp_idx) seq_err <= 1'b1;
      end
      if (ld && !open) seq_err <= 1'b1;
      last2 <= v1 && last1;
      if (v1 && last1) bias_q <= bias;
      y_valid <= last2;
      if (last2) begin
        y   <= y_nxt;
        acc <= '0;
      end else if (v1) begin
        acc <= acc + ACC_W'(prod_q);
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Scoreboard bench for neuron_accumulator (N=4, Q8.8).
// Honours NEURON_RELU_EN for the negative-saturation vector.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_rst = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] index = '0;
  logic [15:0] x_in = '0;
  logic [15:0] w_in = '0;
  logic [15:0] bias = '0;
  logic [15:0] y;
  logic        y_valid;
  logic        seq_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] y;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  logic [15:0] xa[4];
  logic [15:0] wa[4];

  neuron_accumulator #(
    .N    (4),
    .W    (16),
    .FRAC (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .reg_rst (reg_rst),
    .ld      (ld),
    .index   (index),
    .x_in    (x_in),
    .w_in    (w_in),
    .bias    (bias),
    .y       (y),
    .y_valid (y_valid),
    .seq_err (seq_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst && y_valid) begin
      chk("valid_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [15:0] x,
                      input logic [15:0] w);
    ld    = 1'b1;
    index = 16'(i);
    x_in  = x;
    w_in  = w;
    tick();
    ld    = 1'b0;
  endtask

  task automatic clr();
    reg_rst = 1'b1;
    tick();
    reg_rst = 1'b0;
  endtask

  task automatic run4(input logic [15:0] b, input int gap,
                      input bit expect_out, input logic [15:0] want);
    bias = b;
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && expect_out) q.push_back('{want, cyc + 3});
      send(i, xa[i], wa[i]);
      if (i == 1) repeat (gap) tick();
    end
  endtask

  task automatic set_base();
    xa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wa = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_valid", 32'(y_valid), 32'h0);
    chk("rst_seq_err", 32'(seq_err), 32'h0);
    rst = 1'b1;
    tick();

    set_base();
    run4(16'h0080, 0, 1'b1, 16'h0A80);
    repeat (5) tick();
    chk("base_seq_err", 32'(seq_err), 32'h0);
    chk("base_hold", 32'(y), 32'h0A80);
    clr();

    xa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    wa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run4(16'h7FFF, 0, 1'b1, 16'h7FFF);
    repeat (5) tick();
    clr();

    wa = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
`ifdef NEURON_RELU_EN
    run4(16'h0000, 0, 1'b1, 16'h0000);
`else
    run4(16'h0000, 0, 1'b1, 16'h8000);
`endif
    repeat (5) tick();
    clr();

    set_base();
    run4(16'h0080, 2, 1'b1, 16'h0A80);
    repeat (5) tick();
    clr();

    bias = 16'h0080;
    send(0, 16'h0100, 16'h0100);
    send(1, 16'h0100, 16'h0200);
    chk("seq_ok", 32'(seq_err), 32'h0);
    q.push_back('{16'h0680, cyc + 3});
    send(3, 16'h0100, 16'h0300);
    chk("seq_set", 32'(seq_err), 32'h1);
    send(3, 16'h0100, 16'h0400);
    repeat (5) tick();
    chk("seq_sticky", 32'(seq_err), 32'h1);
    clr();
    chk("seq_clr", 32'(seq_err), 32'h0);

    set_base();
    run4(16'h0080, 0, 1'b0, 16'h0000);
    clr();
    repeat (5) tick();
    chk("rr_hold", 32'(y), 32'h0680);
    run4(16'h0080, 0, 1'b1, 16'h0A80);
    repeat (5) tick();
    clr();

    send(0, 16'h0100, 16'h0100);
    send(2, 16'h0100, 16'h0200);
    chk("pre_rst_seq_err", 32'(seq_err), 32'h1);
    rst = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_valid", 32'(y_valid), 32'h0);
    chk("arst_seq_err", 32'(seq_err), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    run4(16'h0080, 0, 1'b1, 16'h0A80);

    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    chk("drain", 32'(q.size()), 32'h0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
